// File: rtl/rca_serial_add_ctrl.sv
// Sequencer that feeds an external 4-bit ripple-carry adder one nibble per cycle,
// LSB nibble first, chaining carries and assembling a DW-bit sum with flags.
module rca_serial_add_ctrl #(
  parameter  int NIBBLES = 4,
  localparam int DW      = 4 * NIBBLES
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] op_a,
  input  logic [DW-1:0] op_b,
  input  logic          cin,
  output logic [3:0]    add_a,
  output logic [3:0]    add_b,
  output logic          add_cin,
  input  logic [3:0]    add_sum,
  input  logic          add_cout,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] result,
  output logic          cout,
  output logic          ovf,
  output logic          busy
);

  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   a_sh_q, a_sh_d;
  logic [DW-1:0]   b_sh_q, b_sh_d;
  logic            carry_q, carry_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [DW-1:0]   result_q, result_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic            last_nib;

  assign last_nib = (idx_q == IW'(NIBBLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_sh_d  = op_a;
          b_sh_d  = op_b;
          carry_d = cin;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Sum nibbles enter at the top so the LSB nibble ends up at [3:0].
        result_d = DW'({add_sum, result_q} >> 4);
        carry_d  = add_cout;
        a_sh_d   = a_sh_q >> 4;
        b_sh_d   = b_sh_q >> 4;
        idx_d    = idx_q + IW'(1);
        if (last_nib) begin
          cout_d  = add_cout;
          ovf_d   = (a_sh_q[3] == b_sh_q[3]) && (add_sum[3] != a_sh_q[3]);
          idx_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign add_a     = (state_q == S_RUN) ? a_sh_q[3:0] : 4'h0;
  assign add_b     = (state_q == S_RUN) ? b_sh_q[3:0] : 4'h0;
  assign add_cin   = (state_q == S_RUN) ? carry_q : 1'b0;
  assign result    = result_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_rca_serial_add_ctrl.sv
// Scoreboard bench for rca_serial_add_ctrl with a behavioural 4-bit adder on the add_* ports.
module tb_rca_serial_add_ctrl;

  localparam int NIB = 4;
  localparam int DW  = 4 * NIB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [DW-1:0] op_a, op_b;
  logic          cin;
  logic [3:0]    add_a, add_b, add_sum;
  logic          add_cin, add_cout;
  logic          out_valid, out_ready;
  logic [DW-1:0] result;
  logic          cout, ovf, busy;

  rca_serial_add_ctrl #(.NIBBLES(NIB)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .cin(cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .ovf(ovf), .busy(busy)
  );

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] res;
    logic          co;
    logic          ov;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [3:0] seq_a[16];
  logic [3:0] seq_b[16];
  logic       seq_c[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
  endtask

  // Monitor: one scoreboard entry per completed output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 32'(result), 32'hDEAD_BEEF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", 32'(result), 32'(e.res));
        chk("cout", 32'(cout), 32'(e.co));
        chk("ovf", 32'(ovf), 32'(e.ov));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Issue one operation; returns the number of edges from accept until out_valid.
  task automatic do_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic c,
                       input logic [DW-1:0] r, input logic co, input logic ov,
                       output int lat);
    int w = 0;
    while (!in_ready && w < 50) begin tick(); w++; end
    chk("in_ready_before_op", 32'(in_ready), 32'd1);
    exp_q.push_back('{res: r, co: co, ov: ov});
    in_valid = 1'b1; op_a = a; op_b = b; cin = c;
    tick();
    in_valid = 1'b0; op_a = ~a; op_b = ~b; cin = ~c;
    lat = 0;
    while (!out_valid && lat < 16) begin
      seq_a[lat] = add_a; seq_b[lat] = add_b; seq_c[lat] = add_cin;
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; in_valid = 1'b0; op_a = '0; op_b = '0; cin = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags", {30'd0, cout, ovf}, 32'd0);
    chk("rst_add", {23'd0, add_a, add_b, add_cin}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // 1: simple add, latency
    do_op(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, lat);
    chk("latency_t1", 32'(lat), 32'd4);
    tick();

    // 2: carry ripple, add_cin per nibble
    do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, lat);
    chk("latency_t2", 32'(lat), 32'd4);
    chk("add_cin_seq", {28'd0, seq_c[0], seq_c[1], seq_c[2], seq_c[3]}, 32'b0111);
    tick();

    // 3: signed overflow cases
    do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, lat);
    tick();
    do_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, lat);
    tick();

    // 4: nibble ordering on the adder ports
    do_op(16'hA5C3, 16'h0110, 1'b0, 16'hA6D3, 1'b0, 1'b0, lat);
    chk("add_a_seq", {16'd0, seq_a[0], seq_a[1], seq_a[2], seq_a[3]}, 32'h3C5A);
    chk("add_b_seq", {16'd0, seq_b[0], seq_b[1], seq_b[2], seq_b[3]}, 32'h0110);
    tick();
    chk("add_idle_zero", {23'd0, add_a, add_b, add_cin}, 32'd0);
    chk("result_held_idle", 32'(result), 32'hA6D3);

    // 5: backpressure in DONE with in_valid pulses
    out_ready = 1'b0;
    do_op(16'h1111, 16'h2222, 1'b1, 16'h3334, 1'b0, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; op_a = 16'(i * 16'h0F0F); op_b = 16'h5555; cin = 1'b1;
      tick();
      chk("hold_result", 32'(result), 32'h3334);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("release_idle_ready", 32'(in_ready), 32'd1);
    chk("release_out_valid", 32'(out_valid), 32'd0);
    chk("release_busy", 32'(busy), 32'd0);

    // 6: reset mid-RUN aborts, then a fresh op
    in_valid = 1'b1; op_a = 16'hFFFF; op_b = 16'hFFFF; cin = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("busy_before_abort", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_add", {23'd0, add_a, add_b, add_cin}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    do_op(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, lat);
    chk("latency_t6", 32'(lat), 32'd4);
    tick(); tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
